// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

    localparam int MAX_N = 16;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Select width never collapses below one bit, so N=1 still has an index port.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Lowest bit of channel idx inside a flattened N*W data bus.
    function automatic int chan_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward with wrap
// using a double-width request vector and a borrow-based mask.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] base;
    logic [2*N-1:0] dbl_grant;

    // Subtracting a one at ptr borrows from the first request at or above ptr;
    // the upper copy of the request vector supplies the wrap-around case.
    always_comb begin
        dbl       = {req, req};
        base      = '0;
        base[ptr] = 1'b1;
        dbl_grant = dbl & ~(dbl - base);
        grant     = dbl_grant[N-1:0] | dbl_grant[2*N-1:N];
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx = SEL_W'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrating N-to-1 mux with a single registered output stage
// and valid/ready handshakes on both sides.
// Optional burst locking is enabled by defining RR_ARB_MUX_LOCK_EN, which adds
// the in_last port and holds the grant on one channel until its last word.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [N-1:0]     in_last,
`endif
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_sel
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic             any_req;
    logic             load_en;
    logic             xfer;
    logic             xfer_last;
    logic [W-1:0]     grant_word;

`ifdef RR_ARB_MUX_LOCK_EN
    logic             locked;
    logic [N-1:0]     lock_mask;

    // While a burst is open only the channel that started it may compete.
    always_comb begin
        lock_mask = '1;
        if (locked) begin
            lock_mask          = '0;
            lock_mask[out_sel] = 1'b1;
        end
        req       = in_valid & lock_mask;
        xfer_last = |(in_last & grant);
    end

    // Burst lock opens on a non-last transfer and closes on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
        end else if (xfer) begin
            locked <= !xfer_last;
        end
    end
`else
    assign req       = in_valid;
    assign xfer_last = 1'b1;
`endif

    rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (any_req)
    );

    // Handshake decode, granted-word select and next priority pointer.
    always_comb begin
        load_en    = !out_valid || out_ready;
        xfer       = !rst && load_en && any_req;
        in_ready   = xfer ? grant : '0;
        grant_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_word = in_data[chan_lo(i, W) +: W];
            end
        end
        ptr_next = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Output stage: load on transfer, drop valid on a bare drain, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_word;
            out_sel   <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Priority pointer moves past the served channel only at an arbitration point.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer && xfer_last) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (N=4, W=8): directed vector table,
// optional burst-lock sequence, then randomized traffic against a reference model.
module tb_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 8;
`ifdef RR_ARB_MUX_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  tb_last;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_sel;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_ptr;
    logic       m_v;
    logic [7:0] m_d;
    logic [1:0] m_s;
    bit         m_locked;

    rr_arb_mux #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last   (tb_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_v;
        logic [7:0]  e_d;
        logic [1:0]  e_s;
    } vec_t;

    localparam logic [31:0] D  = 32'h44332211;
    localparam logic [31:0] D2 = 32'h55332211;

    vec_t vecs [25];

    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d,
                                 input logic ordy, input logic [3:0] last);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        tb_last   = last;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_rdy, input logic e_v,
                               input logic [7:0] e_d, input logic [1:0] e_s);
        n_checks++;
        if (in_ready !== e_rdy || out_valid !== e_v || out_data !== e_d || out_sel !== e_s) begin
            $display("[TB] FAIL %s: got rdy=%b v=%b d=%h s=%0d, need rdy=%b v=%b d=%h s=%0d",
                     name, in_ready, out_valid, out_data, out_sel, e_rdy, e_v, e_d, e_s);
        end else begin
            n_pass++;
        end
    endtask

    // Reference grant: first valid channel scanning upward from the pointer,
    // or only the locked channel while a burst is open.
    function automatic int modelGrant();
        if (rst) return -1;
        if (m_locked) return in_valid[m_s] ? int'(m_s) : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] modelReady();
        int g;
        g = modelGrant();
        if (g >= 0 && (!m_v || out_ready)) return 4'(1) << g;
        return 4'b0000;
    endfunction

    task automatic modelUpdate();
        int g;
        logic [3:0] eff_last;
        g = modelGrant();
        eff_last = LOCK ? tb_last : 4'hF;
        if (rst) begin
            m_ptr = 0; m_v = 1'b0; m_d = 8'h00; m_s = 2'd0; m_locked = 1'b0;
        end else if (g >= 0 && (!m_v || out_ready)) begin
            m_d = in_data[g*8 +: 8];
            m_s = 2'(g);
            m_v = 1'b1;
            if (eff_last[g]) m_ptr = (g + 1) % N;
            m_locked = LOCK && !eff_last[g];
        end else if (m_v && out_ready) begin
            m_v = 1'b0;
        end
    endtask

    task automatic finishCycle();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic lockStep(input string name, input logic r, input logic [3:0] last,
                            input logic [3:0] e_rdy, input logic e_v,
                            input logic [7:0] e_d, input logic [1:0] e_s);
        applyStimulus(r, 4'hF, D, 1'b1, last);
        #1;
        checkOutput(name, e_rdy, e_v, e_d, e_s);
        finishCycle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hF, D,  1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[1]  = '{1'b1, 4'hF, D,  1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[2]  = '{1'b0, 4'hF, D,  1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
        vecs[3]  = '{1'b0, 4'hF, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd0};
        vecs[4]  = '{1'b0, 4'hF, D,  1'b1, 4'b0100, 1'b1, 8'h22, 2'd1};
        vecs[5]  = '{1'b0, 4'hF, D,  1'b1, 4'b1000, 1'b1, 8'h33, 2'd2};
        vecs[6]  = '{1'b0, 4'hF, D,  1'b1, 4'b0001, 1'b1, 8'h44, 2'd3};
        vecs[7]  = '{1'b0, 4'hF, D,  1'b1, 4'b0010, 1'b1, 8'h11, 2'd0};
        vecs[8]  = '{1'b0, 4'hF, D,  1'b1, 4'b0100, 1'b1, 8'h22, 2'd1};
        vecs[9]  = '{1'b0, 4'h1, D,  1'b1, 4'b0001, 1'b1, 8'h33, 2'd2};
        vecs[10] = '{1'b0, 4'h4, D,  1'b1, 4'b0100, 1'b1, 8'h11, 2'd0};
        vecs[11] = '{1'b0, 4'h2, D,  1'b1, 4'b0010, 1'b1, 8'h33, 2'd2};
        vecs[12] = '{1'b0, 4'hF, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        vecs[13] = '{1'b0, 4'hF, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        vecs[14] = '{1'b0, 4'hF, D,  1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        vecs[15] = '{1'b0, 4'hF, D,  1'b1, 4'b0100, 1'b1, 8'h22, 2'd1};
        vecs[16] = '{1'b0, 4'h8, D2, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd2};
        vecs[17] = '{1'b0, 4'h0, D2, 1'b1, 4'b0000, 1'b1, 8'h55, 2'd3};
        vecs[18] = '{1'b0, 4'h0, D2, 1'b1, 4'b0000, 1'b0, 8'h55, 2'd3};
        vecs[19] = '{1'b0, 4'hF, D2, 1'b0, 4'b0001, 1'b0, 8'h55, 2'd3};
        vecs[20] = '{1'b0, 4'h0, D2, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        vecs[21] = '{1'b1, 4'hF, D2, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd0};
        vecs[22] = '{1'b0, 4'h0, D2, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[23] = '{1'b0, 4'h2, D2, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0};
        vecs[24] = '{1'b0, 4'h0, D2, 1'b1, 4'b0000, 1'b1, 8'h22, 2'd1};

        applyStimulus(1'b1, 4'hF, D, 1'b1, 4'hF);
        finishCycle();

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].ordy, 4'hF);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_v, vecs[i].e_d, vecs[i].e_s);
            finishCycle();
        end

`ifdef RR_ARB_MUX_LOCK_EN
        lockStep("lock_rst",   1'b1, 4'hF,    4'b0000, 1'b0, 8'h00, 2'd0);
        lockStep("lock_ch0",   1'b0, 4'hF,    4'b0001, 1'b0, 8'h00, 2'd0);
        lockStep("lock_b1",    1'b0, 4'b0000, 4'b0010, 1'b1, 8'h11, 2'd0);
        lockStep("lock_b2",    1'b0, 4'b0000, 4'b0010, 1'b1, 8'h22, 2'd1);
        lockStep("lock_b3",    1'b0, 4'b0010, 4'b0010, 1'b1, 8'h22, 2'd1);
        lockStep("lock_next",  1'b0, 4'b0000, 4'b0100, 1'b1, 8'h22, 2'd1);
        lockStep("lock_hold",  1'b0, 4'b0000, 4'b0100, 1'b1, 8'h33, 2'd2);
        lockStep("lock_mrst",  1'b1, 4'b0000, 4'b0000, 1'b1, 8'h33, 2'd2);
        lockStep("lock_clear", 1'b0, 4'b0000, 4'b0001, 1'b0, 8'h00, 2'd0);
`endif

        applyStimulus(1'b1, 4'h0, D, 1'b1, 4'hF);
        finishCycle();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, 4'($urandom), $urandom,
                          $urandom_range(0, 3) != 0, 4'($urandom));
            #1;
            checkOutput($sformatf("rand%0d", i), modelReady(), m_v, m_d, m_s);
            finishCycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the combinational n-to-1 mux.
- Selects one of N W-bit channels using round-robin arbitration, not an external select.
- Registers the chosen word into a single output stage with valid/ready handshakes on both sides.
- Sits between multiple requesters (e.g. fetch/load/DMA) and a shared bus or register-file write port.

Parameters:
- N, 4, number of input channels; legal range 1..16.
- W, 8, data width per channel in bits.
- SEL_W, derived, select width: max(1, clog2(N)). Localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high. Sampled only on the rising edge of clk.
- in_data  in  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel request/valid.
- in_ready  out  N  per-channel accept; at most one bit is high in any cycle.
- out_data  out  W  registered selected word.
- out_valid  out  1  out_data holds an untaken word.
- out_ready  in  1  downstream accept.
- out_sel  out  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0 (channel 0 has highest priority). in_ready is all-zero while rst=1.
- Reset mid-operation: a held output word is discarded; no handshake completes in the reset cycle.
- load_en = !out_valid | out_ready.
- Arbitration is combinational:
  - Search channels starting at ptr, ascending with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
  - The first channel with in_valid high is granted, g.
  - in_ready[g] = load_en. All other in_ready bits are 0.
  - With no valid request, in_ready is all-zero.
- Input transfer: in_valid[g] & in_ready[g] at a clk edge. Effects on that edge:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1.
  - ptr <= (g+1) mod N. When g = N-1, ptr wraps to 0.
- Output drain without refill: out_valid & out_ready with no input transfer gives out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and refill in one cycle: the new word replaces the old. Sustained throughput is 1 word/cycle.
- Latency: an accepted input word appears on out_data exactly 1 cycle later.
- Stall (out_valid=1 & out_ready=0):
  - load_en=0, so all in_ready=0.
  - out_data, out_sel and ptr are held stable.
- ptr changes only on an input transfer. An idle cycle does not advance it.
- Fairness: each continuously requesting channel is served within N transfers.
- in_ready depends combinationally on in_valid. Sources must not make in_valid depend on in_ready.
- N=1: ptr is a constant 0, the block reduces to a 1-deep pipeline register, and out_sel is always 0.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- With the macro defined:
  - Extra input port in_last, N bits.
  - A grant is held (locked) on channel g from its first transfer until a transfer with in_last[g]=1.
  - While locked, only channel g may be granted; other requests wait.
  - ptr advances only on the transfer carrying last.
  - Reset clears the lock.
- Without the macro:
  - in_last port is absent.
  - Every transfer is an arbitration point, as described in Behaviour.

Decomposition:
- Package rr_arb_mux_pkg holds:
  - clog2 constant function.
  - Maximum-channel constant MAX_N=16.
  - Helper for the channel slice index.
- Sub-module rr_arbiter: N-bit request vector plus ptr in; one-hot grant and encoded index out.
  - Purely combinational, with no clk.
  - Implemented with the double-width request / mask technique.
- The top level owns the output register, the ptr register, handshake logic and the optional lock flop.

Test Plan (N=4, W=8):
- Reset: assert rst for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0x00, out_sel=0 throughout.
- Rotation: in_data={0x44,0x33,0x22,0x11}, in_valid=1111, out_ready=1 held -> out_data sequence 0x11,0x22,0x33,0x44,0x11 with out_sel 0,1,2,3,0 on consecutive cycles.
- Sparse and wrap: ptr=3 after serving ch2, in_valid=0001 -> ch0 granted, out_sel=0, ptr becomes 1. Then in_valid=0100 -> ch2 granted.
- Backpressure:
  - Setup: out_valid=1 with 0x22, out_ready=0 for 3 cycles, in_valid=1111.
  - Required during stall: in_ready=0000, out_data stays 0x22.
  - Then raise out_ready: the next channel after 1 transfers on the same edge.
- Drain only: a single word 0x55 on ch3, then in_valid=0000 -> out_valid falls 1 cycle after the out_ready handshake. ptr=0.
- Lock (RR_ARB_MUX_LOCK_EN):
  - Stimulus: ch1 sends 3 words with in_last on the 3rd, in_valid=1111.
  - Required: out_sel=1,1,1, then 2.
  - Mid-burst rst: lock is cleared and the next grant is ch0.
